// File: rtl/memcapture_axi.sv
// AXI-Stream capture buffer with AXI-lite readback of words, STATUS and CTRL.
// Define MEMCAPTURE_WRAP_EN for circular capture with sticky overflow.
module memcapture_axi #(
    parameter int    DEPTH     = 256,
    parameter int    WIDTH     = 40,
    parameter string RAM_STYLE = "auto",
    localparam int LANES = 2 ** $clog2((WIDTH + 31) / 32),
    localparam int AXILITE_ADDR_WIDTH = $clog2(DEPTH * LANES) + 3,
    localparam int TW = ((WIDTH + 7) / 8) * 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          s_axis_0_tready_o,
    input  logic                          s_axis_0_tvalid_i,
    input  logic [TW-1:0]                 s_axis_0_tdata_i,
    output logic                          awready_o,
    input  logic                          awvalid_i,
    input  logic [2:0]                    awprot_i,
    input  logic [AXILITE_ADDR_WIDTH-1:0] awaddr_i,
    output logic                          wready_o,
    input  logic                          wvalid_i,
    input  logic [31:0]                   wdata_i,
    input  logic [3:0]                    wstrb_i,
    input  logic                          bready_i,
    output logic                          bvalid_o,
    output logic [1:0]                    bresp_o,
    output logic                          arready_o,
    input  logic                          arvalid_i,
    input  logic [2:0]                    arprot_i,
    input  logic [AXILITE_ADDR_WIDTH-1:0] araddr_i,
    input  logic                          rready_i,
    output logic                          rvalid_o,
    output logic [1:0]                    rresp_o,
    output logic [31:0]                   rdata_o
);

    localparam int AW  = AXILITE_ADDR_WIDTH;
    localparam int LB  = $clog2(LANES);
    localparam int LBW = (LB > 0) ? LB : 1;
    localparam int WB  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = LANES * 32;

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] ram_q;

    logic            armed_q, armed_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;
    logic [WB-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;

    logic            rd_busy_q, rd_busy_d;
    logic            p1_q, p1_d;
    logic            p1_buf_q, p1_buf_d;
    logic            p1_err_q, p1_err_d;
    logic [LBW-1:0]  p1_lane_q, p1_lane_d;
    logic [31:0]     p1_csr_q, p1_csr_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            aw_hs, ctrl_sel, ctrl_wr, clr, tready, beat;
    logic            ar_hs, r_hs, rd_buf, rd_in_range, rd_ram;
    logic [WB-1:0]   rd_word;
    logic [LBW-1:0]  rd_lane;
    logic [AW-2:0]   rd_off;
    logic [31:0]     status_w, ctrl_w;
    logic [PW-1:0]   ram_sh;
    logic            wrap_flag;
    logic            unused_w;

`ifdef MEMCAPTURE_WRAP_EN
    assign wrap_flag = 1'b1;
`else
    assign wrap_flag = 1'b0;
`endif

    assign status_w = {12'd0, wrap_flag, ovf_q, armed_q, full_q, 16'(count_q)};
    assign ctrl_w   = {31'd0, armed_q};

    always_comb begin
        aw_hs    = awvalid_i & wvalid_i & ~bvalid_q;
        ctrl_sel = awaddr_i[AW-1] & (awaddr_i[AW-2:0] == '0);
        ctrl_wr  = aw_hs & ctrl_sel;
        clr      = ctrl_wr & wdata_i[0];
`ifdef MEMCAPTURE_WRAP_EN
        tready   = ~rst & armed_q & ~clr;
`else
        tready   = ~rst & armed_q & ~full_q & ~clr;
`endif
        beat     = s_axis_0_tvalid_i & tready;

        armed_d  = armed_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (beat) begin
            wr_ptr_d = (wr_ptr_q == WB'(DEPTH - 1)) ? '0 : wr_ptr_q + WB'(1);
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end
`ifdef MEMCAPTURE_WRAP_EN
            else begin
                ovf_d = 1'b1;
            end
`else
            if (count_q == CW'(DEPTH - 1)) begin
                full_d = 1'b1;
            end
`endif
        end
        if (ctrl_wr) begin
            armed_d = wdata_i[0];
        end
        if (clr) begin
            wr_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
            ovf_d    = 1'b0;
        end
`ifndef MEMCAPTURE_WRAP_EN
        ovf_d = 1'b0;
`endif

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (aw_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = ctrl_sel ? 2'b00 : 2'b10;
        end else if (bready_i) begin
            bvalid_d = 1'b0;
        end

        ar_hs       = arvalid_i & ~rd_busy_q;
        r_hs        = rvalid_q & rready_i;
        rd_buf      = ~araddr_i[AW-1];
        rd_word     = araddr_i[2+LB +: WB];
        rd_lane     = LBW'((araddr_i >> 2) & AW'(LANES - 1));
        rd_off      = araddr_i[AW-2:0];
        rd_in_range = 32'(rd_word) < DEPTH;
        rd_ram      = ar_hs & rd_buf & rd_in_range;

        rd_busy_d = rd_busy_q;
        if (ar_hs) begin
            rd_busy_d = 1'b1;
        end else if (r_hs) begin
            rd_busy_d = 1'b0;
        end

        p1_d      = ar_hs;
        p1_buf_d  = p1_buf_q;
        p1_err_d  = p1_err_q;
        p1_lane_d = p1_lane_q;
        p1_csr_d  = p1_csr_q;
        if (ar_hs) begin
            p1_buf_d  = rd_buf;
            p1_lane_d = rd_lane;
            p1_err_d  = 1'b0;
            p1_csr_d  = '0;
            if (rd_buf) begin
                p1_err_d = ~rd_in_range;
            end else if (rd_off == '0) begin
                p1_csr_d = ctrl_w;
            end else if (rd_off == (AW-1)'(4)) begin
                p1_csr_d = status_w;
            end else begin
                p1_err_d = 1'b1;
            end
        end

        // Lane select on the zero-extended RAM word; upper lanes read zero.
        ram_sh = PW'(ram_q) >> {p1_lane_q, 5'd0};

        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (p1_q) begin
            rvalid_d = 1'b1;
            rresp_d  = p1_err_q ? 2'b10 : 2'b00;
            if (p1_err_q) begin
                rdata_d = '0;
            end else if (p1_buf_q) begin
                rdata_d = ram_sh[31:0];
            end else begin
                rdata_d = p1_csr_q;
            end
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    // Read-first single-port behaviour: a same-cycle write is not forwarded.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem_q[wr_ptr_q] <= s_axis_0_tdata_i[WIDTH-1:0];
        end
        if (rd_ram) begin
            ram_q <= mem_q[rd_word];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rd_busy_q <= 1'b0;
            p1_q      <= 1'b0;
            p1_buf_q  <= 1'b0;
            p1_err_q  <= 1'b0;
            p1_lane_q <= '0;
            p1_csr_q  <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            armed_q   <= armed_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rd_busy_q <= rd_busy_d;
            p1_q      <= p1_d;
            p1_buf_q  <= p1_buf_d;
            p1_err_q  <= p1_err_d;
            p1_lane_q <= p1_lane_d;
            p1_csr_q  <= p1_csr_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axis_0_tready_o = tready;
    assign awready_o         = aw_hs;
    assign wready_o          = aw_hs;
    assign bvalid_o          = bvalid_q;
    assign bresp_o           = bresp_q;
    assign arready_o         = ~rd_busy_q;
    assign rvalid_o          = rvalid_q;
    assign rresp_o           = rresp_q;
    assign rdata_o           = rdata_q;

    assign unused_w = ^{awprot_i, arprot_i, wstrb_i, wdata_i, s_axis_0_tdata_i,
                        awaddr_i, araddr_i, (RAM_STYLE == "auto")};

endmodule

// File: tb/tb_memcapture_axi.sv
// Directed bench for memcapture_axi (DEPTH=4, WIDTH=40) plus a DEPTH=3 instance
// for the out-of-range word check; expectations come from a small buffer model.
module tb_memcapture_axi;

`ifdef MEMCAPTURE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [5:0] CTRL = 6'h20;
    localparam logic [5:0] STAT = 6'h24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        s_tready, s_tvalid = 1'b0;
    logic [39:0] s_tdata = '0;
    logic        awready, awvalid = 1'b0, wready, wvalid = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        bready = 1'b0, bvalid, arready, arvalid = 1'b0;
    logic        rready = 1'b0, rvalid;
    logic [1:0]  bresp, rresp;

    logic        u3_tready, u3_awready, u3_wready, u3_bvalid, u3_arready;
    logic        u3_arvalid = 1'b0, u3_rready = 1'b0, u3_rvalid;
    logic [5:0]  u3_araddr = '0;
    logic [1:0]  u3_bresp, u3_rresp;
    logic [31:0] u3_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;
    rexp_t      rq[$];
    logic [1:0] bq[$];

    logic [39:0] mdl [4];
    int m_cnt = 0;
    int m_ptr = 0;
    bit m_full = 1'b0;
    bit m_ovf = 1'b0;
    bit m_armed = 1'b1;

    always #5 clk = ~clk;

    memcapture_axi #(.DEPTH(4), .WIDTH(40), .RAM_STYLE("auto")) dut (
        .clk(clk), .rst(rst),
        .s_axis_0_tready_o(s_tready), .s_axis_0_tvalid_i(s_tvalid),
        .s_axis_0_tdata_i(s_tdata),
        .awready_o(awready), .awvalid_i(awvalid), .awprot_i(3'd0),
        .awaddr_i(awaddr),
        .wready_o(wready), .wvalid_i(wvalid), .wdata_i(wdata),
        .wstrb_i(4'hF),
        .bready_i(bready), .bvalid_o(bvalid), .bresp_o(bresp),
        .arready_o(arready), .arvalid_i(arvalid), .arprot_i(3'd0),
        .araddr_i(araddr),
        .rready_i(rready), .rvalid_o(rvalid), .rresp_o(rresp),
        .rdata_o(rdata)
    );

    memcapture_axi #(.DEPTH(3), .WIDTH(40), .RAM_STYLE("auto")) u3 (
        .clk(clk), .rst(rst),
        .s_axis_0_tready_o(u3_tready), .s_axis_0_tvalid_i(1'b0),
        .s_axis_0_tdata_i(40'd0),
        .awready_o(u3_awready), .awvalid_i(1'b0), .awprot_i(3'd0),
        .awaddr_i(6'd0),
        .wready_o(u3_wready), .wvalid_i(1'b0), .wdata_i(32'd0),
        .wstrb_i(4'd0),
        .bready_i(1'b0), .bvalid_o(u3_bvalid), .bresp_o(u3_bresp),
        .arready_o(u3_arready), .arvalid_i(u3_arvalid), .arprot_i(3'd0),
        .araddr_i(u3_araddr),
        .rready_i(u3_rready), .rvalid_o(u3_rvalid), .rresp_o(u3_rresp),
        .rdata_o(u3_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {12'd0, WRAP, m_ovf, m_armed, m_full, 16'(m_cnt)};
    endfunction

    function automatic logic [31:0] m_word(input int w, input int l);
        logic [39:0] v;
        v = mdl[w];
        return (l == 0) ? v[31:0] : {24'd0, v[39:32]};
    endfunction

    function automatic bit m_tready();
        return m_armed && (WRAP || !m_full);
    endfunction

    task automatic m_accept(input logic [39:0] d);
        mdl[m_ptr] = d;
        m_ptr = (m_ptr + 1) % 4;
        if (m_cnt < 4) m_cnt++;
        else m_ovf = 1'b1;
        if (!WRAP && m_cnt == 4) m_full = 1'b1;
    endtask

    task automatic m_clear();
        m_cnt = 0;
        m_ptr = 0;
        m_full = 1'b0;
        m_ovf = 1'b0;
        m_armed = 1'b1;
    endtask

    task automatic stream(input int n, input logic [39:0] base, output int acc);
        int cyc;
        logic [39:0] d;
        acc = 0;
        cyc = 0;
        @(negedge clk);
        d = base;
        s_tdata = d;
        s_tvalid = 1'b1;
        while (acc < n && cyc < 12) begin
            #1;
            chk("tready", 32'(s_tready), 32'(m_tready()));
            if (s_tready) begin
                m_accept(d);
                acc++;
                d = base + 40'(acc);
            end
            @(negedge clk);
            cyc++;
            s_tdata = d;
        end
        if (acc == n) s_tvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [5:0] a, input logic [31:0] ed,
                             input logic [1:0] er, input string tag);
        int n;
        rexp_t e;
        rq.push_back({ed, er});
        @(negedge clk);
        araddr = a;
        arvalid = 1'b1;
        rready = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        e = rq.pop_front();
        chk({tag, "_rdata"}, rdata, e.d);
        chk({tag, "_rresp"}, 32'(rresp), 32'(e.r));
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic axil_write(input logic [5:0] a, input logic [31:0] d,
                              input logic [1:0] er, input bit with_beat,
                              input string tag);
        int n;
        bq.push_back(er);
        @(negedge clk);
        awaddr = a;
        wdata = d;
        awvalid = 1'b1;
        wvalid = 1'b1;
        bready = 1'b1;
        if (with_beat) begin
            s_tdata = 40'h33_0000_00FF;
            s_tvalid = 1'b1;
        end
        #1;
        chk({tag, "_awready"}, 32'({awready, wready}), 32'd3);
        if (with_beat) chk({tag, "_tready_clr"}, 32'(s_tready), 32'd0);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        s_tvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(bresp), 32'(bq.pop_front()));
        @(negedge clk);
        bready = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        rexp_t e;

        #3;
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        axil_read(STAT, m_status(), 2'b00, "stat_reset");

        stream(3, 40'h11_0000_0001, acc);
        chk("acc3", 32'(acc), 32'd3);
        axil_read(STAT, m_status(), 2'b00, "stat_3");
        axil_read(6'h08, m_word(1, 0), 2'b00, "w1l0");
        axil_read(6'h0C, m_word(1, 1), 2'b00, "w1l1");

        axil_write(CTRL, 32'd1, 2'b00, 1'b0, "clr1");
        m_clear();
        stream(6, 40'h22_0000_0001, acc);
        chk("acc6", 32'(acc), WRAP ? 32'd6 : 32'd4);
        #1;
        chk("tready_after", 32'(s_tready), 32'(m_tready()));
        @(negedge clk);
        s_tvalid = 1'b0;
        axil_read(STAT, m_status(), 2'b00, "stat_full");
        axil_read(6'h00, m_word(0, 0), 2'b00, "w0_full");
        axil_read(6'h08, m_word(1, 0), 2'b00, "w1_full");
        axil_read(6'h1C, m_word(3, 1), 2'b00, "w3_full");

        axil_write(CTRL, 32'd1, 2'b00, 1'b0, "clr2");
        m_clear();
        axil_write(CTRL, 32'd1, 2'b00, 1'b1, "clr_beat");
        m_clear();
        axil_read(STAT, m_status(), 2'b00, "stat_clr");
        stream(2, 40'h33_0000_0001, acc);
        chk("acc2", 32'(acc), 32'd2);
        axil_read(6'h00, m_word(0, 0), 2'b00, "w0_resume");
        axil_read(6'h04, m_word(0, 1), 2'b00, "w0l1_resume");
        axil_read(STAT, m_status(), 2'b00, "stat_resume");

        axil_write(6'h00, 32'hDEAD_BEEF, 2'b10, 1'b0, "wr_buf");
        axil_read(6'h00, m_word(0, 0), 2'b00, "w0_after_bad");
        axil_write(STAT, 32'hFFFF_FFFF, 2'b10, 1'b0, "wr_stat");
        axil_read(STAT, m_status(), 2'b00, "stat_after_bad");
        axil_read(6'h28, 32'd0, 2'b10, "csr_bad");
        axil_read(CTRL, 32'(m_armed), 2'b00, "ctrl_rd");

        @(negedge clk);
        araddr = 6'h08;
        arvalid = 1'b1;
        rready = 1'b0;
        rq.push_back({m_word(1, 0), 2'b00});
        #1;
        chk("ar_idle", 32'(arready), 32'd1);
        @(negedge clk);
        chk("rvalid_t1", 32'(rvalid), 32'd0);
        #1;
        chk("ar_busy", 32'(arready), 32'd0);
        @(negedge clk);
        chk("rvalid_t2", 32'(rvalid), 32'd1);
        e = rq.pop_front();
        chk("rdata_t2", rdata, e.d);
        repeat (3) @(negedge clk);
        chk("rvalid_hold", 32'(rvalid), 32'd1);
        chk("rdata_hold", rdata, e.d);
        chk("rresp_hold", 32'(rresp), 32'(e.r));
        chk("ar_hold", 32'(arready), 32'd0);
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        chk("rvalid_done", 32'(rvalid), 32'd0);
        chk("ar_free", 32'(arready), 32'd1);
        rready = 1'b0;

        axil_write(CTRL, 32'd0, 2'b00, 1'b0, "disarm");
        m_armed = 1'b0;
        @(negedge clk);
        s_tdata = 40'h44_0000_0001;
        s_tvalid = 1'b1;
        #1;
        chk("tready_disarm", 32'(s_tready), 32'd0);
        @(negedge clk);
        s_tvalid = 1'b0;
        axil_read(STAT, m_status(), 2'b00, "stat_disarm");
        axil_read(CTRL, 32'(m_armed), 2'b00, "ctrl_disarm");

        @(negedge clk);
        araddr = STAT;
        arvalid = 1'b1;
        rready = 1'b0;
        awaddr = CTRL;
        wdata = 32'd1;
        awvalid = 1'b1;
        wvalid = 1'b1;
        bready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid = 1'b0;
        m_clear();
        chk("bvalid_pre_rst", 32'(bvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_bvalid", 32'(bvalid), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_tready", 32'(s_tready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_rvalid", 32'(rvalid), 32'd0);
        chk("post_rst_bvalid", 32'(bvalid), 32'd0);
        axil_read(STAT, m_status(), 2'b00, "stat_post_rst");
        axil_read(6'h10, m_word(2, 0), 2'b00, "w2_kept");
        axil_read(6'h14, m_word(2, 1), 2'b00, "w2l1_kept");

        rq.push_back({32'd0, 2'b10});
        @(negedge clk);
        u3_araddr = 6'h18;
        u3_arvalid = 1'b1;
        u3_rready = 1'b1;
        @(negedge clk);
        u3_arvalid = 1'b0;
        n = 0;
        while (!u3_rvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("oor_rvalid", 32'(u3_rvalid), 32'd1);
        e = rq.pop_front();
        chk("oor_rdata", u3_rdata, e.d);
        chk("oor_rresp", 32'(u3_rresp), 32'(e.r));
        @(negedge clk);
        u3_rready = 1'b0;

        rq.push_back({{12'd0, WRAP, 3'b010, 16'd0}, 2'b00});
        @(negedge clk);
        u3_araddr = STAT;
        u3_arvalid = 1'b1;
        u3_rready = 1'b1;
        @(negedge clk);
        u3_arvalid = 1'b0;
        n = 0;
        while (!u3_rvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("u3_stat_rvalid", 32'(u3_rvalid), 32'd1);
        e = rq.pop_front();
        chk("u3_stat_rdata", u3_rdata, e.d);
        chk("u3_stat_rresp", 32'(u3_rresp), 32'(e.r));
        @(negedge clk);
        u3_rready = 1'b0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
